note_sequencer: RTL and testbench
=================================

# note_sequencer

Parametrised, runtime-programmable note sequencer for one PWM audio channel. A small on-chip step memory holds (note, length) pairs, written through a simple write port. The block plays them under start/stop control, once or looping, and drives phase delta, envelope and PWM top to the channel's PWM/DDS datapath. It is the generic replacement for the per-channel hard-coded sequencers.

## Interface
Parameters:
- `SEQ_DEPTH`, 16: number of step-memory entries; power of two, ≥2.
- `ADDR_W`, $clog2(SEQ_DEPTH): step address width.
- `LEN_W`, 5: note-length field width, counted in note strobes.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_tick_stb`  in  1  envelope/vibrato tick, one-cycle pulse.
- `i_note_stb`  in  1  duration tick, one-cycle pulse.
- `i_start`  in  1  pulse; (re)start playback at step 0.
- `i_stop`  in  1  pulse; halt playback.
- `i_loop`  in  1  1 = wrap after last step; 0 = stop after last step.
- `i_last_step`  in  ADDR_W  index of the final step to play.
- `i_wr_en`  in  1  step-memory write strobe.
- `i_wr_addr`  in  ADDR_W  write address.
- `i_wr_note`  in  6  note code (0 = rest).
- `i_wr_len`  in  LEN_W  note length code.
- `o_top`  out  8  PWM top; constant 8'hff.
- `o_top_valid`  out  1  equals `o_playing`.
- `o_phase_delta`  out  32  DDS phase increment.
- `o_envelope`  out  9  amplitude.
- `o_step`  out  ADDR_W  current step index.
- `o_playing`  out  1  state == PLAY.
- `o_new_note`  out  1  registered pulse; first cycle of each note.
- `o_done`  out  1  registered pulse; one-shot run finished.

## Operation
- FSM has two states, IDLE and PLAY. Reset enters IDLE.
- IDLE → PLAY on `i_start`: step 0, duration count 0, envelope and vibrato indices 0, `o_new_note` pulses next cycle.
- PLAY on `i_start`: restart identically.
- PLAY on `i_stop`: go to IDLE. `o_done` does not pulse. `i_stop` wins over a simultaneous `i_start`.
- In PLAY, on `i_note_stb`:
  - If count == len of the current step, the note ends: count ← 0. A note therefore lasts len+1 note strobes.
  - Otherwise count ← count+1.
- At note end:
  - If `o_step` ≥ `i_last_step`: with `i_loop`=1 go to step 0 and pulse `o_new_note`; with `i_loop`=0 go to IDLE and pulse `o_done`.
  - Otherwise step ← step+1 and pulse `o_new_note`.
- Envelope index: reset to 0 on each new note. Otherwise increments on `i_tick_stb` and saturates at 15. `o_envelope` = ENV_TABLE[index].
- Rest note (code 0): `o_envelope` = 0, `o_phase_delta` = 0.
- `o_phase_delta` = note_table(note) for the current step.
- In IDLE: `o_phase_delta` = 0, `o_envelope` = 0, `o_step` holds its last value.
- Step memory has no reset.
  - Read is combinational at `o_step`.
  - Writes are accepted in any state.
  - A write to the current step changes outputs the next cycle and compares against the new length from then on.
- Arithmetic:
  - Duration count is LEN_W bits. The length comparison is equality.
  - Step increment is ADDR_W bits; it wraps naturally at SEQ_DEPTH-1 when `i_last_step` ≥ SEQ_DEPTH-1.

## Timing
- All state registers and pulse outputs reset to 0. `o_top` is 8'hff at all times.
- Start → PLAY and outputs valid: 1 cycle. `o_new_note` is high in that same first PLAY cycle.
- Note-end `i_note_stb` at cycle N → new `o_step` and `o_new_note` at N+1.
- `o_done` at N+1, coincident with `o_playing` falling.
- `i_note_stb` coinciding with `i_start`: start wins and count stays 0.
- Asserting reset mid-note returns the block to IDLE immediately, with no `o_done` pulse.

## Configuration
- `NOTE_SEQ_VIBRATO_EN` defined:
  - A 3-bit vibrato index resets on each new note and wraps 7→0 on `i_tick_stb`.
  - For non-rest notes, `o_phase_delta` = base + sign-extended VIB_TABLE[index] (mod 2^32).
- `NOTE_SEQ_VIBRATO_EN` undefined: the vibrato logic is absent and `o_phase_delta` = base.

## Structure
- Shared package `note_seq_pkg`:
  - ENV_TABLE, 16 entries: 6,8,12,14,16,18,20,20,20,22,24,24,26,30,30,30.
  - VIB_TABLE, 8 entries: 0,−0x71B,−0xAFA,−0x71B,0,0x79E,0xB1F,0x79E.
  - NOTE_RST = 0.
  - FSM state encoding.
- One sub-module: the existing `note_table` (note code → phase increment). It is instantiated once.

## Test plan
- Load steps 0..2 = (Cs5,len 1),(Fs5,len 0),(rest,len 2), `i_last_step`=2, `i_loop`=0, start; pulse `i_note_stb` 6 times → steps last 2,1,3 strobes, then `o_done` pulses once and `o_phase_delta`=0.
- Same program with `i_loop`=1 → after step 2 the sequencer returns to step 0 with `o_new_note` pulsed; it never reaches IDLE.
- New note, then 20 `i_tick_stb` → `o_envelope` follows 6,8,12… and saturates at 30; `o_new_note` returns it to 6.
- `i_start` and `i_stop` in the same cycle during PLAY → IDLE, no `o_done`. `i_start` during PLAY at step 3 → step 0 next cycle.
- Rewrite the current step's note while it plays → `o_phase_delta` changes the following cycle.
- With `NOTE_SEQ_VIBRATO_EN`, 2 ticks into a note → `o_phase_delta` = base − 0xAFA; without the macro → base.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared types and lookup tables for the note sequencer: FSM encoding,
// the rest-note code, envelope and vibrato tables.
package note_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } seq_state_e;

  localparam logic [5:0] NOTE_RST = 6'd0;

  function automatic logic [8:0] env_lut(input logic [3:0] idx);
    logic [8:0] env;
    case (idx)
      4'd0:    env = 9'd6;
      4'd1:    env = 9'd8;
      4'd2:    env = 9'd12;
      4'd3:    env = 9'd14;
      4'd4:    env = 9'd16;
      4'd5:    env = 9'd18;
      4'd6:    env = 9'd20;
      4'd7:    env = 9'd20;
      4'd8:    env = 9'd20;
      4'd9:    env = 9'd22;
      4'd10:   env = 9'd24;
      4'd11:   env = 9'd24;
      4'd12:   env = 9'd26;
      default: env = 9'd30;
    endcase
    return env;
  endfunction

  // Signed phase offsets around the base pitch, one period per 8 ticks.
  function automatic logic signed [12:0] vib_lut(input logic [2:0] idx);
    logic signed [12:0] vib;
    case (idx)
      3'd0:    vib = 13'sd0;
      3'd1:    vib = -13'sd1819;
      3'd2:    vib = -13'sd2810;
      3'd3:    vib = -13'sd1819;
      3'd4:    vib = 13'sd0;
      3'd5:    vib = 13'sd1950;
      3'd6:    vib = 13'sd2847;
      default: vib = 13'sd1950;
    endcase
    return vib;
  endfunction

endpackage

// File: rtl/note_table.sv
// Note code to DDS phase increment. Code 0 is a rest; codes 1..63 map to
// semitones from C1 upward, derived from the octave-6 increments by shifting.
module note_table (
  input  logic [5:0]  i_note,
  output logic [31:0] o_delta
);

  logic [5:0]  idx;
  logic [2:0]  oct;
  logic [3:0]  semi;
  logic [31:0] top;

  assign idx  = i_note - 6'd1;
  assign oct  = 3'(idx / 6'd12);
  assign semi = 4'(idx % 6'd12);

  // Octave-6 increments for a 50 MHz phase accumulator clock.
  always_comb begin
    top = 32'd0;
    case (semi)
      4'd0:    top = 32'd89894;
      4'd1:    top = 32'd95240;
      4'd2:    top = 32'd100903;
      4'd3:    top = 32'd106903;
      4'd4:    top = 32'd113260;
      4'd5:    top = 32'd119994;
      4'd6:    top = 32'd127128;
      4'd7:    top = 32'd134688;
      4'd8:    top = 32'd142698;
      4'd9:    top = 32'd151183;
      4'd10:   top = 32'd160173;
      4'd11:   top = 32'd169697;
      default: top = 32'd0;
    endcase
  end

  assign o_delta = (i_note == 6'd0) ? 32'd0 : (top >> (3'd5 - oct));

endmodule

// File: rtl/note_sequencer.sv
// Programmable (note, length) step sequencer driving one PWM/DDS channel.
// Define NOTE_SEQ_VIBRATO_EN to add a per-tick vibrato offset to the phase delta.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int SEQ_DEPTH = 16,
  parameter int ADDR_W    = $clog2(SEQ_DEPTH),
  parameter int LEN_W     = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick_stb,
  input  logic              i_note_stb,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_last_step,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [5:0]        i_wr_note,
  input  logic [LEN_W-1:0]  i_wr_len,
  output logic [7:0]        o_top,
  output logic              o_top_valid,
  output logic [31:0]       o_phase_delta,
  output logic [8:0]        o_envelope,
  output logic [ADDR_W-1:0] o_step,
  output logic              o_playing,
  output logic              o_new_note,
  output logic              o_done
);

  logic [5:0]       note_mem [SEQ_DEPTH];
  logic [LEN_W-1:0] len_mem  [SEQ_DEPTH];

  seq_state_e        state_q;
  logic [ADDR_W-1:0] step_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [3:0]        env_idx_q;
  logic              new_note_q;
  logic              done_q;

  logic [5:0]       cur_note;
  logic [LEN_W-1:0] cur_len;
  logic [31:0]      base_delta;
  logic             note_end;
  logic             at_last;
  logic             restart_note;
  logic             sounding;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      note_mem[i_wr_addr] <= i_wr_note;
      len_mem[i_wr_addr]  <= i_wr_len;
    end
  end

  assign cur_note = note_mem[step_q];
  assign cur_len  = len_mem[step_q];
  assign note_end = i_note_stb && (cnt_q == cur_len);
  assign at_last  = (step_q >= i_last_step);

  // Any event that begins a fresh note: start/restart or a note end that keeps playing.
  always_comb begin
    restart_note = 1'b0;
    if (state_q == ST_IDLE) begin
      restart_note = i_start;
    end else if (!i_stop) begin
      restart_note = i_start || (note_end && (!at_last || i_loop));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      cnt_q      <= '0;
      env_idx_q  <= '0;
      new_note_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      new_note_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q    <= ST_PLAY;
            step_q     <= '0;
            cnt_q      <= '0;
            env_idx_q  <= '0;
            new_note_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (i_stop) begin
            state_q <= ST_IDLE;
          end else if (i_start) begin
            step_q     <= '0;
            cnt_q      <= '0;
            env_idx_q  <= '0;
            new_note_q <= 1'b1;
          end else begin
            if (i_tick_stb && (env_idx_q != 4'd15)) begin
              env_idx_q <= env_idx_q + 4'd1;
            end
            if (note_end) begin
              cnt_q <= '0;
              if (at_last && !i_loop) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end else begin
                step_q     <= at_last ? '0 : step_q + ADDR_W'(1);
                env_idx_q  <= '0;
                new_note_q <= 1'b1;
              end
            end else if (i_note_stb) begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  note_table u_note_table (
    .i_note  (cur_note),
    .o_delta (base_delta)
  );

  assign sounding = (state_q == ST_PLAY) && (cur_note != NOTE_RST);

`ifdef NOTE_SEQ_VIBRATO_EN
  logic [2:0]         vib_idx_q;
  logic signed [31:0] vib_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vib_idx_q <= '0;
    end else if (restart_note) begin
      vib_idx_q <= '0;
    end else if ((state_q == ST_PLAY) && i_tick_stb) begin
      vib_idx_q <= vib_idx_q + 3'd1;
    end
  end

  assign vib_ext       = 32'(vib_lut(vib_idx_q));
  assign o_phase_delta = sounding ? (base_delta + $unsigned(vib_ext)) : 32'd0;
`else
  assign o_phase_delta = sounding ? base_delta : 32'd0;
`endif

  assign o_envelope  = sounding ? env_lut(env_idx_q) : 9'd0;
  assign o_top       = 8'hff;
  assign o_playing   = (state_q == ST_PLAY);
  assign o_top_valid = o_playing;
  assign o_step      = step_q;
  assign o_new_note  = new_note_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with hand-computed expected values.
module tb_note_sequencer;

  logic        clk;
  logic        rst_n;
  logic        tick_stb;
  logic        note_stb;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [3:0]  last_step;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [5:0]  wr_note;
  logic [4:0]  wr_len;
  logic [7:0]  top;
  logic        top_valid;
  logic [31:0] phase_delta;
  logic [8:0]  envelope;
  logic [3:0]  step;
  logic        playing;
  logic        new_note;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  // Hand-computed increments: Cs5 = 95240>>1, Fs5 = 127128>>1, C1 = 89894>>5.
  localparam logic [31:0] PD_CS5 = 32'd47620;
  localparam logic [31:0] PD_FS5 = 32'd63564;
  localparam logic [31:0] PD_C1  = 32'd2809;

  logic [31:0] env_exp [16] = '{6, 8, 12, 14, 16, 18, 20, 20, 20, 22, 24, 24, 26, 30, 30, 30};

  note_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_tick_stb    (tick_stb),
    .i_note_stb    (note_stb),
    .i_start       (start),
    .i_stop        (stop),
    .i_loop        (loop_en),
    .i_last_step   (last_step),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_note     (wr_note),
    .i_wr_len      (wr_len),
    .o_top         (top),
    .o_top_valid   (top_valid),
    .o_phase_delta (phase_delta),
    .o_envelope    (envelope),
    .o_step        (step),
    .o_playing     (playing),
    .o_new_note    (new_note),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_note();
    note_stb = 1'b1;
    cycle();
    note_stb = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_stb = 1'b1;
    cycle();
    tick_stb = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic write_step(input logic [3:0] a, input logic [5:0] n, input logic [4:0] l);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_note = n;
    wr_len  = l;
    cycle();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_stb = 1'b0; note_stb = 1'b0; start = 1'b0; stop = 1'b0;
    loop_en = 1'b0; last_step = 4'd2; wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_len = '0;
    repeat (3) cycle();

    // Reset state
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_valid", 32'(top_valid), 32'd0);
    chk("rst_new_note", 32'(new_note), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_phase", phase_delta, 32'd0);
    chk("rst_env", 32'(envelope), 32'd0);
    chk("rst_top", 32'(top), 32'hff);
    rst_n = 1'b1;
    cycle();

    // One-shot program: (Cs5,1) (Fs5,0) (rest,2)
    write_step(4'd0, 6'd50, 5'd1);
    write_step(4'd1, 6'd55, 5'd0);
    write_step(4'd2, 6'd0, 5'd2);
    pulse_start();
    chk("os_playing", 32'(playing), 32'd1);
    chk("os_valid", 32'(top_valid), 32'd1);
    chk("os_new_note0", 32'(new_note), 32'd1);
    chk("os_step0", 32'(step), 32'd0);
    chk("os_phase0", phase_delta, PD_CS5);
    chk("os_env0", 32'(envelope), 32'd6);
    cycle();
    chk("os_new_note_drop", 32'(new_note), 32'd0);
    pulse_note();
    chk("os_step0_hold", 32'(step), 32'd0);
    chk("os_nn_hold", 32'(new_note), 32'd0);
    pulse_note();
    chk("os_step1", 32'(step), 32'd1);
    chk("os_new_note1", 32'(new_note), 32'd1);
    chk("os_phase1", phase_delta, PD_FS5);
    pulse_note();
    chk("os_step2", 32'(step), 32'd2);
    chk("os_rest_phase", phase_delta, 32'd0);
    chk("os_rest_env", 32'(envelope), 32'd0);
    pulse_note();
    pulse_note();
    chk("os_rest_hold", 32'(playing), 32'd1);
    chk("os_done_early", 32'(done), 32'd0);
    pulse_note();
    chk("os_done", 32'(done), 32'd1);
    chk("os_idle", 32'(playing), 32'd0);
    chk("os_idle_step", 32'(step), 32'd2);
    chk("os_idle_phase", phase_delta, 32'd0);
    cycle();
    chk("os_done_pulse", 32'(done), 32'd0);

    // Looping program
    loop_en = 1'b1;
    pulse_start();
    chk("lp_step0", 32'(step), 32'd0);
    repeat (6) pulse_note();
    chk("lp_wrap_step", 32'(step), 32'd0);
    chk("lp_wrap_nn", 32'(new_note), 32'd1);
    chk("lp_playing", 32'(playing), 32'd1);
    chk("lp_no_done", 32'(done), 32'd0);

    // Envelope ramp and saturation on step 0
    chk("env_k0", 32'(envelope), 32'd6);
    for (int k = 1; k <= 20; k++) begin
      pulse_tick();
      chk($sformatf("env_k%0d", k), 32'(envelope), env_exp[(k > 15) ? 15 : k]);
      if (k == 2) begin
`ifdef NOTE_SEQ_VIBRATO_EN
        chk("vib_2ticks", phase_delta, PD_CS5 - 32'h0AFA);
`else
        chk("vib_2ticks", phase_delta, PD_CS5);
`endif
      end
    end
    pulse_note();
    pulse_note();
    chk("env_newnote_nn", 32'(new_note), 32'd1);
    chk("env_newnote_step", 32'(step), 32'd1);
    chk("env_newnote_reset", 32'(envelope), 32'd6);

    // Rewrite the playing step's note
    chk("rw_before", phase_delta, PD_FS5);
    write_step(4'd1, 6'd50, 5'd0);
    chk("rw_after", phase_delta, PD_CS5);
    write_step(4'd1, 6'd55, 5'd0);

    // Simultaneous start and stop during PLAY: stop wins, no done
    start = 1'b1;
    stop  = 1'b1;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_idle", 32'(playing), 32'd0);
    chk("ss_no_done", 32'(done), 32'd0);
    chk("ss_no_nn", 32'(new_note), 32'd0);

    // Restart from step 3, with a coincident note strobe
    write_step(4'd3, 6'd1, 5'd0);
    last_step = 4'd3;
    pulse_start();
    repeat (6) pulse_note();
    chk("rs_step3", 32'(step), 32'd3);
    chk("rs_phase3", phase_delta, PD_C1);
    start    = 1'b1;
    note_stb = 1'b1;
    cycle();
    start    = 1'b0;
    note_stb = 1'b0;
    chk("rs_step0", 32'(step), 32'd0);
    chk("rs_nn", 32'(new_note), 32'd1);
    pulse_note();
    chk("rs_cnt_zero", 32'(step), 32'd0);
    pulse_note();
    chk("rs_step1", 32'(step), 32'd1);

    // Asynchronous reset mid-note
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_idle", 32'(playing), 32'd0);
    chk("ar_no_done", 32'(done), 32'd0);
    chk("ar_step", 32'(step), 32'd0);
    chk("ar_phase", phase_delta, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
